// File: rtl/cobs_multichannel_packetizer.sv
// cobs_multichannel_packetizer
//
// Purpose:
//   Collects one sample from each of NUM_CHANNELS AXI-Stream inputs. Once every
//   channel has delivered a sample, it emits the samples as one COBS-encoded
//   frame terminated by a 0x00 delimiter. Channel 0 goes first, and each sample
//   is sent MSB byte first. The next set of samples can be collected while the
//   current frame is being emitted.
//
// Optional feature:
//   `define COBS_PKT_SEQ_EN puts an 8-bit sequence byte in front of the samples.
//   The sequence byte is encoded together with the samples. The counter steps
//   once per emitted delimiter and wraps from 255 to 0.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   ch_tdata    NUM_CHANNELS samples, channel i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   ch_tvalid   per-channel valid
//   ch_tready   per-channel ready (high while that channel's capture slot is empty)
//   pkt_tdata   COBS-encoded output byte
//   pkt_tvalid  output valid
//   pkt_tready  downstream ready
//   pkt_tlast   high only on the 0x00 frame delimiter
module cobs_multichannel_packetizer #(
  parameter int NUM_CHANNELS = 2,
  parameter int SAMPLE_BYTES = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CHANNELS*8*SAMPLE_BYTES-1:0] ch_tdata,
  input  logic [NUM_CHANNELS-1:0]               ch_tvalid,
  output logic [NUM_CHANNELS-1:0]               ch_tready,
  output logic [7:0]                            pkt_tdata,
  output logic                                  pkt_tvalid,
  input  logic                                  pkt_tready,
  output logic                                  pkt_tlast
);

  localparam int SAMPLE_WIDTH = 8 * SAMPLE_BYTES;
  localparam int DATA_BYTES   = NUM_CHANNELS * SAMPLE_BYTES;
`ifdef COBS_PKT_SEQ_EN
  localparam int SEQ_BYTES    = 1;
`else
  localparam int SEQ_BYTES    = 0;
`endif
  localparam int PAYLOAD_BYTES = DATA_BYTES + SEQ_BYTES;
  // The position register can reach PAYLOAD_BYTES. It also has to hold
  // PAYLOAD_BYTES+1, which is the value of pos+1 while pos sits at the end.
  localparam int POS_W = $clog2(PAYLOAD_BYTES + 2);

  // Reject parameter values that are out of range when the design elaborates.
  generate
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_bad_num_channels
      $error("NUM_CHANNELS must be in 1..8");
    end
    if (SAMPLE_BYTES < 1 || SAMPLE_BYTES > 4) begin : g_bad_sample_bytes
      $error("SAMPLE_BYTES must be in 1..4");
    end
    if (DATA_BYTES + 1 > 253) begin : g_bad_payload
      $error("NUM_CHANNELS*SAMPLE_BYTES + 1 must not exceed 253");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    EMIT_CODE,
    EMIT_DATA,
    EMIT_DELIM
  } state_t;

  state_t                                     state_q, state_d;
  logic [POS_W-1:0]                           pos_q, pos_d, pos_p1;
  logic [NUM_CHANNELS-1:0]                    slot_full_q;
  logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0]  slot_data_q;
  logic [PAYLOAD_BYTES*8-1:0]                 payload_d, payload_q;
  logic                                       load;
  logic [7:0]                                 run_len;
  logic [7:0]                                 cur_byte;
  logic                                       next_zero;
  logic                                       scan_stop;
  logic                                       at_end;
  logic                                       next_at_end;

  // ---------------------------------------------------------------------------
  // Capture slots
  // ---------------------------------------------------------------------------
  assign ch_tready = ~slot_full_q;

  // The payload is loaded only while the encoder is idle, so a full set of
  // slots simply waits until the current frame has been fully emitted.
  assign load = (&slot_full_q) && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full_q <= '0;
      slot_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (load) begin
          slot_full_q[i] <= 1'b0;
        end else if (ch_tvalid[i] && !slot_full_q[i]) begin
          slot_full_q[i] <= 1'b1;
          slot_data_q[i] <= ch_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Payload assembly. Byte k of the payload sits at payload[k*8 +: 8] and is
  // sent k-th.
  // ---------------------------------------------------------------------------
  genvar gi, gb;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      for (gb = 0; gb < SAMPLE_BYTES; gb++) begin : g_byte
        assign payload_d[(SEQ_BYTES + gi*SAMPLE_BYTES + gb)*8 +: 8] =
          slot_data_q[gi][(SAMPLE_BYTES-1-gb)*8 +: 8];
      end
    end
  endgenerate

`ifdef COBS_PKT_SEQ_EN
  logic [7:0] seq_q;

  assign payload_d[7:0] = seq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q <= 8'h00;
    end else if (state_q == EMIT_DELIM && pkt_tready) begin
      seq_q <= seq_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      payload_q <= '0;
    end else if (load) begin
      payload_q <= payload_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Block scan
  //   run_len   = number of non-zero bytes from pos_q up to the next zero byte
  //               or the end of the payload
  //   cur_byte  = payload byte at pos_q
  //   next_zero = the payload byte at pos_q+1 is 0x00
  // ---------------------------------------------------------------------------
  assign pos_p1      = pos_q + POS_W'(1);
  assign at_end      = (pos_q == POS_W'(PAYLOAD_BYTES));
  assign next_at_end = (pos_p1 == POS_W'(PAYLOAD_BYTES));

  always_comb begin
    scan_stop = 1'b0;
    run_len   = 8'd0;
    cur_byte  = 8'h00;
    next_zero = 1'b0;
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      if (POS_W'(k) == pos_q) begin
        cur_byte = payload_q[k*8 +: 8];
      end
      if (POS_W'(k) == pos_p1) begin
        next_zero = (payload_q[k*8 +: 8] == 8'h00);
      end
      if ((POS_W'(k) >= pos_q) && !scan_stop) begin
        if (payload_q[k*8 +: 8] == 8'h00) begin
          scan_stop = 1'b1;
        end else begin
          run_len = run_len + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Encoder FSM. The outputs depend only on registered state, so they hold
  // steady while the downstream side stalls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    pkt_tvalid = 1'b0;
    pkt_tdata  = 8'h00;
    pkt_tlast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = EMIT_CODE;
          pos_d   = '0;
        end
      end
      EMIT_CODE: begin
        pkt_tvalid = 1'b1;
        pkt_tdata  = run_len + 8'd1;
        if (pkt_tready) begin
          if (run_len != 8'd0) begin
            state_d = EMIT_DATA;
          end else if (at_end) begin
            state_d = EMIT_DELIM;
          end else begin
            // The block is empty and pos_q points at a zero byte. Consume the
            // zero byte and start the next block.
            pos_d = pos_p1;
          end
        end
      end
      EMIT_DATA: begin
        pkt_tvalid = 1'b1;
        pkt_tdata  = cur_byte;
        if (pkt_tready) begin
          if (next_at_end) begin
            state_d = EMIT_DELIM;
          end else if (next_zero) begin
            // Step over the zero byte that ends this block.
            pos_d   = pos_q + POS_W'(2);
            state_d = EMIT_CODE;
          end else begin
            pos_d = pos_p1;
          end
        end
      end
      EMIT_DELIM: begin
        pkt_tvalid = 1'b1;
        pkt_tlast  = 1'b1;
        if (pkt_tready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cobs_multichannel_packetizer.sv
// Directed testbench for cobs_multichannel_packetizer. It uses the default
// parameters plus a second instance with NUM_CHANNELS=1. When COBS_PKT_SEQ_EN
// is defined, the sequence-byte scenarios run instead of the plain ones.
`timescale 1ns/1ps
module tb_cobs_multichannel_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ch_tdata = '0;
  logic [1:0]  ch_tvalid = '0;
  logic [1:0]  ch_tready;
  logic [7:0]  pkt_tdata;
  logic        pkt_tvalid;
  logic        pkt_tready = 1'b1;
  logic        pkt_tlast;

  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  s_pkt_tdata;
  logic        s_pkt_tvalid;
  logic        s_pkt_tready = 1'b1;
  logic        s_pkt_tlast;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] rx_q[$];
  logic       rx_last[$];
  logic [7:0] srx_q[$];
  logic       srx_last[$];

  cobs_multichannel_packetizer #(.NUM_CHANNELS(2), .SAMPLE_BYTES(2)) u_dut (
    .clk(clk), .reset(reset),
    .ch_tdata(ch_tdata), .ch_tvalid(ch_tvalid), .ch_tready(ch_tready),
    .pkt_tdata(pkt_tdata), .pkt_tvalid(pkt_tvalid), .pkt_tready(pkt_tready),
    .pkt_tlast(pkt_tlast)
  );

  cobs_multichannel_packetizer #(.NUM_CHANNELS(1), .SAMPLE_BYTES(2)) u_dut_single (
    .clk(clk), .reset(reset),
    .ch_tdata(s_tdata), .ch_tvalid(s_tvalid), .ch_tready(s_tready),
    .pkt_tdata(s_pkt_tdata), .pkt_tvalid(s_pkt_tvalid), .pkt_tready(s_pkt_tready),
    .pkt_tlast(s_pkt_tlast)
  );

  always #5 clk = ~clk;

  // Record each output byte at the falling edge before the rising edge that
  // transfers it.
  always @(negedge clk) begin
    if (!reset && pkt_tvalid && pkt_tready) begin
      rx_q.push_back(pkt_tdata);
      rx_last.push_back(pkt_tlast);
    end
    if (!reset && s_pkt_tvalid && s_pkt_tready) begin
      srx_q.push_back(s_pkt_tdata);
      srx_last.push_back(s_pkt_tlast);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic send_ch(input int ch, input logic [15:0] d, output bit ok);
    int cyc;
    bit done;
    cyc = 0;
    done = 1'b0;
    @(posedge clk); #1;
    ch_tdata[ch*16 +: 16] = d;
    ch_tvalid[ch] = 1'b1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      done = ch_tready[ch];
      @(posedge clk); #1;
      cyc++;
    end
    ch_tvalid[ch] = 1'b0;
    ok = done;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    int cyc;
    cyc = 0;
    while (rx_q.size() < n && cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    ok = (rx_q.size() >= n);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_last.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (pkt_tvalid !== 1'b0 || pkt_tlast !== 1'b0 || pkt_tdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: tvalid=%b tlast=%b tdata=%h, required 0 0 00",
               pkt_tvalid, pkt_tlast, pkt_tdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ch_tready !== 2'b11 || s_tready !== 1'b1 || pkt_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: ch_tready=%b s_tready=%b tvalid=%b, required 11 1 0",
               ch_tready, s_tready, pkt_tvalid);
    end
  endtask

`ifndef COBS_PKT_SEQ_EN
  task automatic test_basic();
    logic [7:0] exp [6];
    bit ok0, ok1, okw;
    exp = '{8'h01, 8'h02, 8'hFF, 8'h02, 8'h7F, 8'h00};
    clear_rx();
    send_ch(0, 16'h00FF, ok0);
    send_ch(1, 16'h007F, ok1);
    wait_bytes(6, okw);
    tests_run++;
    if (!(ok0 && ok1 && okw) || rx_q.size() != 6) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d bytes, required 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (rx_q[i] !== exp[i] || rx_last[i] !== (i == 5)) begin
          tests_failed++;
          $display("FAIL basic_byte%0d: got %h last=%b, required %h last=%b",
                   i, rx_q[i], rx_last[i], exp[i], (i == 5));
        end
      end
    end
  endtask

  task automatic test_patterns();
    logic [7:0] exp_z [6];
    logic [7:0] exp_n [6];
    bit ok0, ok1, okw;
    exp_z = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    exp_n = '{8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    for (int p = 0; p < 2; p++) begin
      clear_rx();
      send_ch(0, (p == 0) ? 16'h0000 : 16'h1234, ok0);
      send_ch(1, (p == 0) ? 16'h0000 : 16'h5678, ok1);
      wait_bytes(6, okw);
      tests_run++;
      if (!(ok0 && ok1 && okw) || rx_q.size() != 6) begin
        tests_failed++;
        $display("FAIL pattern%0d_count: got %0d bytes, required 6", p, rx_q.size());
      end else begin
        for (int i = 0; i < 6; i++) begin
          tests_run++;
          if (rx_q[i] !== ((p == 0) ? exp_z[i] : exp_n[i]) || rx_last[i] !== (i == 5)) begin
            tests_failed++;
            $display("FAIL pattern%0d_byte%0d: got %h last=%b, required %h last=%b",
                     p, i, rx_q[i], rx_last[i], ((p == 0) ? exp_z[i] : exp_n[i]), (i == 5));
          end
        end
      end
    end
  endtask

  task automatic test_single_channel();
    logic [7:0] exp [4];
    int cyc;
    bit done;
    exp = '{8'h02, 8'h7F, 8'h01, 8'h00};
    srx_q.delete();
    srx_last.delete();
    @(posedge clk); #1;
    s_tdata = 16'h7F00;
    s_tvalid = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      done = s_tready;
      @(posedge clk); #1;
      cyc++;
    end
    s_tvalid = 1'b0;
    cyc = 0;
    while (srx_q.size() < 4 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    tests_run++;
    if (srx_q.size() != 4) begin
      tests_failed++;
      $display("FAIL single_count: got %0d bytes, required 4", srx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (srx_q[i] !== exp[i] || srx_last[i] !== (i == 3)) begin
          tests_failed++;
          $display("FAIL single_byte%0d: got %h last=%b, required %h last=%b",
                   i, srx_q[i], srx_last[i], exp[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_late_channel();
    logic [7:0] exp [6];
    bit ok0, ok1, okw;
    exp = '{8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    clear_rx();
    send_ch(0, 16'h1234, ok0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests_run++;
      if (pkt_tvalid !== 1'b0) begin
        tests_failed++;
        $display("FAIL late_idle%0d: tvalid=%b, required 0", c, pkt_tvalid);
      end
    end
    send_ch(1, 16'h5678, ok1);
    @(negedge clk);
    tests_run++;
    if (pkt_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_load_cycle: tvalid=%b, required 0", pkt_tvalid);
    end
    @(negedge clk);
    tests_run++;
    if (pkt_tvalid !== 1'b1 || pkt_tdata !== 8'h05) begin
      tests_failed++;
      $display("FAIL late_first: tvalid=%b tdata=%h, required 1 05", pkt_tvalid, pkt_tdata);
    end
    wait_bytes(6, okw);
    tests_run++;
    if (!(ok0 && ok1 && okw) || rx_q.size() != 6) begin
      tests_failed++;
      $display("FAIL late_count: got %0d bytes, required 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (rx_q[i] !== exp[i] || rx_last[i] !== (i == 5)) begin
          tests_failed++;
          $display("FAIL late_byte%0d: got %h last=%b, required %h last=%b",
                   i, rx_q[i], rx_last[i], exp[i], (i == 5));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp [6];
    logic [7:0] prev_data;
    logic       prev_last;
    bit         prev_stall;
    bit ok0, ok1;
    int cyc;
    exp = '{8'h01, 8'h02, 8'hFF, 8'h02, 8'h7F, 8'h00};
    clear_rx();
    prev_stall = 1'b0;
    prev_data = 8'h00;
    prev_last = 1'b0;
    cyc = 0;
    fork
      begin
        send_ch(0, 16'h00FF, ok0);
        send_ch(1, 16'h007F, ok1);
      end
      begin
        while (rx_q.size() < 6 && cyc < 400) begin
          @(posedge clk); #1;
          pkt_tready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (prev_stall) begin
            tests_run++;
            if (pkt_tvalid !== 1'b1 || pkt_tdata !== prev_data || pkt_tlast !== prev_last) begin
              tests_failed++;
              $display("FAIL stall_hold: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                       pkt_tvalid, pkt_tdata, pkt_tlast, prev_data, prev_last);
            end
          end
          prev_stall = pkt_tvalid && !pkt_tready;
          prev_data = pkt_tdata;
          prev_last = pkt_tlast;
          cyc++;
        end
      end
    join
    @(posedge clk); #1;
    pkt_tready = 1'b1;
    repeat (3) @(posedge clk);
    tests_run++;
    if (!(ok0 && ok1) || rx_q.size() != 6) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d bytes, required 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (rx_q[i] !== exp[i] || rx_last[i] !== (i == 5)) begin
          tests_failed++;
          $display("FAIL stall_byte%0d: got %h last=%b, required %h last=%b",
                   i, rx_q[i], rx_last[i], exp[i], (i == 5));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [12];
    bit ok0, ok1, ok2, ok3, okw;
    exp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
            8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    clear_rx();
    send_ch(0, 16'h0000, ok0);
    send_ch(1, 16'h0000, ok1);
    send_ch(0, 16'h1234, ok2);
    send_ch(1, 16'h5678, ok3);
    wait_bytes(12, okw);
    tests_run++;
    if (!(ok0 && ok1 && ok2 && ok3 && okw) || rx_q.size() != 12) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d bytes, required 12", rx_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        tests_run++;
        if (rx_q[i] !== exp[i] || rx_last[i] !== (i == 5 || i == 11)) begin
          tests_failed++;
          $display("FAIL b2b_byte%0d: got %h last=%b, required %h last=%b",
                   i, rx_q[i], rx_last[i], exp[i], (i == 5 || i == 11));
        end
      end
    end
  endtask
`endif

`ifdef COBS_PKT_SEQ_EN
  task automatic test_seq();
    logic [7:0] exp0 [7];
    logic [7:0] exp1 [7];
    logic [7:0] exp_ff [7];
    logic [7:0] want;
    bit ok0, ok1, okw;
    exp0   = '{8'h01, 8'h01, 8'h02, 8'hFF, 8'h02, 8'h7F, 8'h00};
    exp1   = '{8'h02, 8'h01, 8'h02, 8'hFF, 8'h02, 8'h7F, 8'h00};
    exp_ff = '{8'h02, 8'hFF, 8'h02, 8'hFF, 8'h02, 8'h7F, 8'h00};
    for (int p = 0; p < 257; p++) begin
      clear_rx();
      send_ch(0, 16'h00FF, ok0);
      send_ch(1, 16'h007F, ok1);
      wait_bytes(7, okw);
      if (p == 0 || p == 1 || p == 255 || p == 256) begin
        tests_run++;
        if (!(ok0 && ok1 && okw) || rx_q.size() != 7) begin
          tests_failed++;
          $display("FAIL seq_pkt%0d_count: got %0d bytes, required 7", p, rx_q.size());
        end else begin
          for (int i = 0; i < 7; i++) begin
            want = (p == 1) ? exp1[i] : ((p == 255) ? exp_ff[i] : exp0[i]);
            tests_run++;
            if (rx_q[i] !== want || rx_last[i] !== (i == 6)) begin
              tests_failed++;
              $display("FAIL seq_pkt%0d_byte%0d: got %h last=%b, required %h last=%b",
                       p, i, rx_q[i], rx_last[i], want, (i == 6));
            end
          end
        end
      end
    end
  endtask
`endif

  task automatic test_midreset();
    logic [7:0] exp_q [$];
    logic [7:0] exp_mid;
    bit ok0, ok1, okw;
    int cyc;
`ifdef COBS_PKT_SEQ_EN
    // Runs after 257 packets, so the sequence byte 0x01 is the first data byte.
    exp_mid = 8'h01;
    exp_q = '{8'h01, 8'h01, 8'h02, 8'hFF, 8'h02, 8'h7F, 8'h00};
`else
    exp_mid = 8'h12;
    exp_q = '{8'h01, 8'h02, 8'hFF, 8'h02, 8'h7F, 8'h00};
`endif
    @(posedge clk); #1;
    pkt_tready = 1'b0;
    send_ch(0, 16'h1234, ok0);
    send_ch(1, 16'h5678, ok1);
    cyc = 0;
    while (pkt_tvalid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    pkt_tready = 1'b1;
    @(posedge clk); #1;
    pkt_tready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (!(ok0 && ok1) || pkt_tvalid !== 1'b1 || pkt_tlast !== 1'b0 || pkt_tdata !== exp_mid) begin
      tests_failed++;
      $display("FAIL midreset_data: tvalid=%b tlast=%b tdata=%h, required 1 0 %h",
               pkt_tvalid, pkt_tlast, pkt_tdata, exp_mid);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (pkt_tvalid !== 1'b0 || ch_tready !== 2'b11) begin
      tests_failed++;
      $display("FAIL midreset_after: tvalid=%b ch_tready=%b, required 0 11",
               pkt_tvalid, ch_tready);
    end
    pkt_tready = 1'b1;
    clear_rx();
    send_ch(0, 16'h00FF, ok0);
    send_ch(1, 16'h007F, ok1);
    wait_bytes(exp_q.size(), okw);
    tests_run++;
    if (!(ok0 && ok1 && okw) || rx_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL midreset_count: got %0d bytes, required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (rx_q[i] !== exp_q[i] || rx_last[i] !== (i == exp_q.size() - 1)) begin
          tests_failed++;
          $display("FAIL midreset_byte%0d: got %h last=%b, required %h last=%b",
                   i, rx_q[i], rx_last[i], exp_q[i], (i == exp_q.size() - 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef COBS_PKT_SEQ_EN
    test_seq();
    test_midreset();
`else
    test_basic();
    test_patterns();
    test_single_channel();
    test_late_channel();
    test_stall();
    test_back_to_back();
    test_midreset();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cobs_multichannel_packetizer.md
COBS_MULTICHANNEL_PACKETIZER -- requirements
Module: cobs_multichannel_packetizer

Interface
REQ-001 Parameter NUM_CHANNELS, default 2: number of sample input channels, range 1-8.
REQ-002 Parameter SAMPLE_BYTES, default 2: bytes per sample, range 1-4; SAMPLE_WIDTH = 8*SAMPLE_BYTES.
REQ-003 Constraint: NUM_CHANNELS*SAMPLE_BYTES + 1 SHALL be <= 253; an elaboration-time assertion SHALL reject larger values.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ch_tdata  input  NUM_CHANNELS*SAMPLE_WIDTH  channel i occupies bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-007 ch_tvalid  input  NUM_CHANNELS  per-channel AXIS valid.
REQ-008 ch_tready  output  NUM_CHANNELS  per-channel AXIS ready.
REQ-009 pkt_tdata  output  8  COBS-encoded byte stream.
REQ-010 pkt_tvalid  output  1  output valid.
REQ-011 pkt_tready  input  1  downstream ready.
REQ-012 pkt_tlast  output  1  high only on the 0x00 frame delimiter.

Function
REQ-013 Each channel SHALL have a one-sample capture slot; ch_tready[i] = slot i empty; a transfer (tvalid&&tready) fills the slot.
REQ-014 When all slots are full and the encoder is in IDLE, the payload buffer SHALL load in that cycle and all slots SHALL clear in that cycle, so collection of the next set overlaps emission.
REQ-015 Payload order: channel 0 first, each sample MSB byte first.
REQ-016 The encoder SHALL be an FSM: IDLE -> EMIT_CODE -> EMIT_DATA (code-1 bytes; skipped if code=1) -> EMIT_CODE (when the block ended on a zero byte) or EMIT_DELIM (when the block ended at payload end) -> IDLE.
REQ-017 The code byte SHALL be 1 + the count of non-zero bytes from the current position to the next zero byte or payload end, computed combinationally from a zero-flag vector; the zero byte itself is consumed, not emitted.
REQ-018 A payload ending in 0x00 SHALL produce a trailing code byte 0x01 before the delimiter.
REQ-019 EMIT_DELIM SHALL output 0x00 with pkt_tlast=1.
REQ-020 First pkt_tvalid SHALL occur the cycle after payload load; one byte per cycle while pkt_tready=1.
REQ-021 While pkt_tvalid=1 and pkt_tready=0, pkt_tdata/pkt_tlast SHALL hold stable and the FSM SHALL not advance.
REQ-022 The state SHALL advance only on pkt_tvalid&&pkt_tready; pkt_tvalid SHALL not deassert before the handshake completes.

Reset
REQ-023 On reset: FSM=IDLE, pkt_tvalid=0, pkt_tlast=0, pkt_tdata=0x00, all slots empty (ch_tready all 1 from the cycle after reset deasserts), sequence counter=0.
REQ-024 Reset mid-packet SHALL abandon the packet without emitting a delimiter; a partial frame is acceptable and is resynchronised by the next 0x00.

Configuration
REQ-025 Macro COBS_PKT_SEQ_EN defined: an 8-bit sequence byte SHALL be prepended to the payload (before channel 0), encoded with it; the counter SHALL increment once per emitted delimiter and wrap 255->0.
REQ-026 Macro COBS_PKT_SEQ_EN undefined: no sequence byte and no counter logic; the payload is exactly NUM_CHANNELS*SAMPLE_BYTES bytes.

Verification
REQ-027 Defaults, no SEQ: ch0=0x00FF, ch1=0x007F, pkt_tready=1 -> 01 02 FF 02 7F 00, tlast on the last byte only.
REQ-028 Defaults: ch0=0x0000, ch1=0x0000 -> 01 01 01 01 01 00; ch0=0x1234, ch1=0x5678 -> 05 12 34 56 78 00.
REQ-029 NUM_CHANNELS=1: ch0=0x7F00 -> 02 7F 01 00.
REQ-030 ch1 valid 10 cycles after ch0 -> no pkt_tvalid until the cycle after ch1 is captured; random pkt_tready toggling -> identical byte sequence, data stable under stall.
REQ-031 COBS_PKT_SEQ_EN, samples 0x00FF/0x007F twice -> 01 01 02 FF 02 7F 00 then 02 01 02 FF 02 7F 00; after 256 packets the sequence byte returns to 0x00.
REQ-032 Reset asserted during EMIT_DATA -> next cycle pkt_tvalid=0, ch_tready all 1, sequence byte of the next packet = 0x00.
